// File: rtl/conv_pkg.sv
// Shared pixel/coefficient/accumulator types and the output saturation helper
// used by the 3x3 convolution datapath.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 21;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Arithmetic shift, then clamp into the unsigned 8-bit pixel range.
    function automatic pixel_t sat_u8(input acc_t acc, input logic [3:0] shift);
        acc_t w_sh;
        w_sh = acc >>> shift;
        if (w_sh[ACC_W-1])
            return '0;
        else if (|w_sh[ACC_W-2:PIX_W])
            return '1;
        return w_sh[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// One image line of delay: a circular single-port buffer that reads the
// oldest pixel and overwrites it with the incoming one on each enable.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam int PTR_W = $clog2(IMG_W);

    pixel_t             r_mem [IMG_W];
    logic [PTR_W-1:0]   r_ptr;

    assign dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (en)
            r_mem[r_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (en)
            r_ptr <= (r_ptr == PTR_W'(IMG_W-1)) ? '0 : r_ptr + 1'b1;
    end
endmodule

// File: rtl/conv3x3_core.sv
// Streaming 3x3 convolution: two chained line buffers feed a 3x3 window,
// followed by a multiply/sum/saturate pipeline writing into the output FIFO.
module conv3x3_core
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [71:0] coef,
    input  logic [3:0]  shift,
    input  logic [7:0]  in_pixel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] out_count
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic               w_en, w_acc, w_fr_acc, w_last_px, w_win_ok;
    logic [COL_W-1:0]   r_col, w_col;
    logic [ROW_W-1:0]   r_row, w_row;
    logic               r_busy;
    logic [31:0]        r_count;
    pixel_t             w_lb0, w_lb1;

    pixel_t             r_win_p0 [3][3];
    logic               r_vld_p0, r_last_p0;
    pixel_t             r_pix_p1 [9];
    coef_t              r_coef_p1 [9];
    logic [3:0]         r_shift_p1;
    logic               r_vld_p1, r_last_p1;
    acc_t               r_sum_p2;
    logic [3:0]         r_shift_p2;
    logic               r_vld_p2, r_last_p2;
    pixel_t             r_dout_p3;
    logic               r_vld_p3, r_last_p3;

    logic signed [16:0] w_prod [9];
    acc_t               w_sum;

    assign w_en     = !(r_vld_p3 && fifo_full);
    assign in_ready = w_en && rst_n;
    assign w_acc    = in_valid && in_ready;
    // Pixels arriving outside a frame are swallowed without touching any state.
    assign w_fr_acc = w_acc && (r_busy || start);

    assign w_col     = start ? '0 : r_col;
    assign w_row     = start ? '0 : r_row;
    assign w_last_px = (w_col == COL_W'(IMG_W-1)) && (w_row == ROW_W'(IMG_H-1));
    assign w_win_ok  = (w_col >= COL_W'(2)) && (w_row >= ROW_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_busy <= 1'b0;
        end else begin
            if (start)
                r_busy <= 1'b1;
            if (w_fr_acc) begin
                if (w_col == COL_W'(IMG_W-1)) begin
                    r_col <= '0;
                    if (w_last_px) begin
                        r_row  <= '0;
                        r_busy <= 1'b0;
                    end else begin
                        r_row <= w_row + 1'b1;
                    end
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end else if (start) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    conv_line_buffer #(.IMG_W(IMG_W)) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_fr_acc),
        .din   (in_pixel),
        .dout  (w_lb0)
    );

    conv_line_buffer #(.IMG_W(IMG_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_fr_acc),
        .din   (w_lb0),
        .dout  (w_lb1)
    );

    always_comb begin
        w_prod = '{default: '0};
        w_sum  = '0;
        for (int i = 0; i < 9; i++) begin
            w_prod[i] = 17'($signed({1'b0, r_pix_p1[i]})) * 17'(r_coef_p1[i]);
            w_sum     = w_sum + ACC_W'(w_prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        // p0: window shift, oldest line in row 0, oldest column in column 0
        if (w_fr_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win_p0[r][0] <= r_win_p0[r][1];
                r_win_p0[r][1] <= r_win_p0[r][2];
            end
            r_win_p0[0][2] <= w_lb1;
            r_win_p0[1][2] <= w_lb0;
            r_win_p0[2][2] <= in_pixel;
        end
        if (w_en) begin
            // p1: window and programmable coefficients captured together
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    r_pix_p1[3*r+c]  <= r_win_p0[r][c];
                    r_coef_p1[3*r+c] <= coef[8*(3*r+c) +: 8];
                end
            r_shift_p1 <= shift;
            // p2: products and adder tree
            r_sum_p2   <= w_sum;
            r_shift_p2 <= r_shift_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_last_p3 <= 1'b0;
            r_dout_p3 <= '0;
            r_count   <= '0;
        end else begin
            if (w_en) begin
                r_vld_p0  <= w_fr_acc && w_win_ok;
                r_last_p0 <= w_last_px;
                r_vld_p1  <= r_vld_p0;
                r_last_p1 <= r_last_p0;
                r_vld_p2  <= r_vld_p1;
                r_last_p2 <= r_last_p1;
                // p3: shift and saturate
                r_vld_p3  <= r_vld_p2;
                r_last_p3 <= r_last_p2;
                r_dout_p3 <= sat_u8(r_sum_p2, r_shift_p2);
            end
            if (fifo_wr_en)
                r_count <= r_count + 1'b1;
        end
    end

    assign fifo_wr_en = r_vld_p3 && !fifo_full;
    assign fifo_din   = r_dout_p3;
    assign frame_done = fifo_wr_en && r_last_p3;
    assign busy       = r_busy;
    assign out_count  = r_count;
endmodule

// File: tb/tb_conv3x3_core.sv
// Directed and randomized frames for conv3x3_core on a 5x5 image, compared
// against a direct 2-D convolution reference.
module tb_conv3x3_core;
    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [71:0] coef = '0;
    logic [3:0]  shift = '0;
    logic [7:0]  in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [31:0] out_count;

    int          checks = 0;
    int          errors = 0;
    int          img [NPIX];
    int          kk [9];
    int          sh;
    int          exp_q [$];
    logic [8:0]  cap_q [$];
    longint      exp_total = 0;

    conv3x3_core #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .coef       (coef),
        .shift      (shift),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .frame_done (frame_done),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n === 1'b1 && fifo_wr_en === 1'b1)
            cap_q.push_back({frame_done, fifo_din});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load_coef();
        for (int i = 0; i < 9; i++)
            coef[8*i +: 8] = kk[i][7:0];
        shift = 4'(sh);
    endtask

    function automatic void build_expected();
        exp_q.delete();
        for (int y = 1; y < H - 1; y++)
            for (int x = 1; x < W - 1; x++) begin
                int s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        s += kk[3*r+c] * img[(y - 1 + r) * W + (x - 1 + c)];
                s = s >>> sh;
                if (s < 0) s = 0;
                else if (s > 255) s = 255;
                exp_q.push_back(s);
            end
    endfunction

    task automatic feed_frame(input bit with_px, input bit do_stall, input int abort_at);
        int idx = 0;
        int guard = 0;
        bit stalled = 0;
        bit rdy;
        int bad;
        if (!with_px) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (idx < NPIX && guard < 1000) begin
            if (idx == abort_at) begin
                in_valid = 1'b0;
                return;
            end
            if (do_stall && !stalled && cap_q.size() >= 4) begin
                stalled = 1;
                bad = 0;
                fifo_full = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0 || fifo_wr_en !== 1'b0) bad++;
                    @(posedge clk); #1;
                end
                fifo_full = 1'b0;
                chk("stall_hold", 64'(bad), 64'(0));
            end
            in_valid = 1'b1;
            in_pixel = 8'(img[idx]);
            start    = with_px && (idx == 0);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (rdy) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (do_stall) chk("stall_seen", 64'(stalled), 64'(1));
        chk("feed_done", 64'(idx), 64'(NPIX));
    endtask

    task automatic drain();
        int guard = 0;
        while (cap_q.size() < NOUT && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        build_expected();
        exp_total += NOUT;
        chk({tag, "_count"}, 64'(cap_q.size()), 64'(NOUT));
        for (int i = 0; i < NOUT && i < cap_q.size(); i++) begin
            chk({tag, "_pix"}, 64'(cap_q[i][7:0]), 64'(exp_q[i]));
            chk({tag, "_fd"}, 64'(cap_q[i][8]), 64'(i == NOUT - 1));
        end
        chk({tag, "_out_count"}, 64'(out_count), 64'(exp_total));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic random_frame();
        for (int i = 0; i < NPIX; i++)
            img[i] = int'($urandom_range(0, 255));
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("rst_din", 64'(fifo_din), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // Identity kernel on a ramp
        kk = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        sh = 0;
        for (int i = 0; i < NPIX; i++) img[i] = i;
        load_coef();
        cap_q.delete();
        feed_frame(0, 0, -1);
        drain();
        check_frame("ident");
        chk("ident_first", 64'(cap_q[0][7:0]), 64'(6));
        chk("ident_last", 64'(cap_q[NOUT-1][7:0]), 64'(18));
        chk("ident_total", 64'(out_count), 64'(9));

        // Box sum with shift
        kk = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        sh = 3;
        for (int i = 0; i < NPIX; i++) img[i] = 200;
        load_coef();
        cap_q.delete();
        feed_frame(0, 0, -1);
        drain();
        check_frame("box");
        chk("box_225", 64'(cap_q[4][7:0]), 64'(225));

        // Laplacian: flat field, then a single bright pixel
        kk = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        sh = 0;
        for (int i = 0; i < NPIX; i++) img[i] = 50;
        load_coef();
        cap_q.delete();
        feed_frame(0, 0, -1);
        drain();
        check_frame("lap_flat");
        chk("lap_flat_zero", 64'(cap_q[4][7:0]), 64'(0));
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        img[12] = 255;
        cap_q.delete();
        feed_frame(0, 0, -1);
        drain();
        check_frame("lap_peak");
        chk("lap_peak_sat", 64'(cap_q[4][7:0]), 64'(255));
        chk("lap_neigh_clamp", 64'(cap_q[1][7:0]), 64'(0));

        // Random kernels, one run with a FIFO-full stall
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) kk[i] = int'($urandom_range(0, 255)) - 128;
            sh = int'($urandom_range(4, 10));
            random_frame();
            load_coef();
            cap_q.delete();
            feed_frame(0, (t == 1), -1);
            drain();
            check_frame((t == 1) ? "rand_stall" : "rand");
        end

        // Idle pixels are discarded; start coincides with the first pixel
        chk("idle_busy", 64'(busy), 64'(0));
        cap_q.delete();
        repeat (3) begin
            in_valid = 1'b1;
            in_pixel = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_no_write", 64'(cap_q.size()), 64'(0));
        chk("idle_out_count", 64'(out_count), 64'(exp_total));
        random_frame();
        feed_frame(1, 0, -1);
        drain();
        check_frame("start_px");

        // Reset in the middle of row 3, then a clean frame
        random_frame();
        cap_q.delete();
        feed_frame(0, 0, 17);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("midrst_din", 64'(fifo_din), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_frame_done", 64'(frame_done), 64'(0));
        chk("midrst_out_count", 64'(out_count), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_total = 0;
        cap_q.delete();
        random_frame();
        feed_frame(0, 0, -1);
        drain();
        check_frame("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_core.md
# conv3x3_core

Streaming 3x3 2-D convolution engine; the stage directly upstream of the pixel read-out CSR block. Accepts a raster-ordered 8-bit grayscale stream, keeps two line buffers plus a 3x3 window, multiplies it by nine signed CSR-programmed coefficients, then shifts and saturates to 8 bits. Each valid-region result is written into the output pixel FIFO that the CPU drains through the CSR interface.

## Interface

- IMG_W, 64: image width in pixels (≥3).
- IMG_H, 64: image height in lines (≥3).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear row/col counters and begin a new frame.
- coef  in  72  nine signed 8-bit coefficients; k[r][c] at bits [8*(3r+c)+7 : 8*(3r+c)], r,c ∈ 0..2, r=0 oldest line.
- shift  in  4  arithmetic right shift applied to the sum (0..15).
- in_pixel  in  8  input pixel, unsigned.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  core can accept a pixel this cycle.
- fifo_din  out  8  result pixel to FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full.
- busy  out  1  frame in progress (start seen, last pixel not yet accepted).
- frame_done  out  1  one-cycle pulse when the last result of a frame is written.
- out_count  out  32  results written since reset.

## Operation

- Accept: in_valid && in_ready at a rising edge. Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accept; col wraps to 0 and row increments; after (IMG_W-1, IMG_H-1), both wrap to 0 and busy deasserts.
- start: clears col/row and sets busy. Pipeline contents already in flight still drain to the FIFO. start coincident with an accept: start wins and the pixel is taken as (0,0).
- Pixels accepted while busy=0 are consumed and discarded (no counter update, no output).
- Window: on each accept, the line buffers shift the column. The window becomes line[-2], line[-1], current, with the last three columns each.
- Result is valid only when the accepted pixel has row≥2 and col≥2. Output is (IMG_W-2)x(IMG_H-2) pixels; no border padding.
- Arithmetic:
  - Each pixel is zero-extended to 9 bits signed; product with the 8-bit signed coef is 17 bits.
  - The sum of nine products is 21-bit signed, with no overflow possible.
  - Result is sum >>> shift (arithmetic), saturated to 0 if negative and to 255 if above 255.
- coef/shift are sampled in pipeline stage 1; software changes them only while busy=0.
- Stall: en = !(s3_valid && fifo_full). All pipeline registers and window/line buffers advance only when en. in_ready = en && rst_n released.
- fifo_wr_en = s3_valid && !fifo_full; fifo_din = s3 data.
- frame_done asserts in the same cycle as fifo_wr_en for the result with source (IMG_W-1, IMG_H-1).
- out_count increments on every fifo_wr_en and wraps at 2^32.

## Timing

- Reset values:
  - in_ready=0 while rst_n low; it becomes 1 in the first cycle after release.
  - fifo_wr_en=0, fifo_din=0, busy=0, frame_done=0, out_count=0.
  - col=row=0; all stage valids 0.
  - Line buffer RAM content is don't-care.
- Pipeline: S1 registers the window and valid flag; S2 registers the products and the adder tree sum; S3 registers the shifted and saturated result.
- Latency: a result-producing accept at edge N gives fifo_wr_en=1 during the cycle after edge N+3, when no stall occurs.
- Throughput: 1 pixel/cycle while fifo_full=0.
- A fifo_full assertion holds all of S1..S3 and deasserts in_ready in the same cycle. No data is lost and no duplicate write occurs. Resumption is on the first cycle with fifo_full=0.
- rst_n asserted mid-frame flushes the pipeline immediately. There is no partial write, and the next frame requires start.

## Structure

- conv_pkg:
  - PIX_W=8, COEF_W=8, ACC_W=21.
  - Typedefs pixel_t (logic [7:0]), coef_t (logic signed [7:0]), acc_t (logic signed [20:0]).
  - Function sat_u8(acc_t, shift) returning pixel_t.
- Sub-module conv_line_buffer: a single-port circular buffer of IMG_W x 8 bits with an enable and one column counter. conv3x3_core instantiates two of them chained.

## Test plan

- IMG_W=IMG_H=5, identity kernel (k[1][1]=1, rest 0), shift=0, ramp input 0..24 → 9 writes: 6,7,8,11,12,13,16,17,18; frame_done with the 18; out_count=9.
- All coef=1, shift=3, constant input 200 → every result is 1800>>>3=225.
- Laplacian (centre 8, rest -1), shift=0, constant input 50 → 0. A single 255 pixel centred gives 255 (saturated); its neighbours give 0 (negative clamp).
- Hold fifo_full=1 for 10 cycles mid-frame with in_valid always 1 → in_ready=0 throughout; the write sequence is identical to the unstalled golden run; total writes = 9.
- Assert rst_n low during row 3 → all outputs take their reset values asynchronously. After release and start, a full frame matches golden, and out_count counts only post-reset writes.
- in_valid while busy=0, then start in the same cycle as a valid pixel → the pre-start pixels are discarded and the start-cycle pixel is treated as (0,0).
